muldiv_sequencer: RTL and testbench

- Multi-cycle execute-stage unit for the MUL and REM ALU operations decoded by the control unit; the single-cycle ALU does not implement them.
- Accepts one operation from the ID/EX boundary and computes it iteratively, 1 bit per cycle.
- Holds the pipeline stall line high while busy, then presents a one-cycle result pulse with the destination tag for EX/MEM capture.

---
 rtl/muldiv_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle execute-stage unit for the MUL and REM ALU operations.
//   One operation is accepted from the ID/EX boundary and then computed one
//   bit per cycle:
//     - MUL uses shift-add and keeps the low XLEN bits of the product.
//     - REM uses restoring division on magnitudes; the sign of the result
//       follows the dividend.
//   The pipeline is stalled while the unit is working. A one-cycle result
//   pulse, carrying the destination tag, follows for EX/MEM capture.
//
// Ports
//   clk           pipeline clock
//   reset         asynchronous, active-low reset
//   start         ID/EX holds a valid instruction this cycle
//   alu_op        ALU op code; only ALU_MUL and ALU_REM are acted on
//   op_a, op_b    rs1 / rs2 values (multiplicand/dividend, multiplier/divisor)
//   rd_tag        destination register of the instruction
//   flush         synchronous abort (branch/exception squash)
//   stall         freeze IF/ID/EX pipeline registers
//   busy          FSM not in IDLE
//   result_valid  one-cycle pulse; result and result_tag are valid
//   result        MUL: low XLEN product bits; REM: signed remainder
//   result_tag    rd_tag captured at accept
//   state_dbg     current FSM state, for observation only
//
// Handshake: start is a valid-only request from ID/EX. The unit takes the
// request in the same cycle it raises stall, and stall doubles as the
// not-ready signal. The request is taken only when all of the following hold:
//   - the unit is IDLE,
//   - start is 1,
//   - alu_op is MUL or REM,
//   - flush is 0.
// Every other request is dropped silently. result_valid is a pulse with no
// back-pressure, because EX/MEM always captures it.
module muldiv_sequencer #(
  parameter int         XLEN    = 32,
  parameter int         TAG_W   = 5,
  parameter logic [4:0] ALU_MUL = 5'd10,
  parameter logic [4:0] ALU_REM = 5'd13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alu_op,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] result_tag,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    REM_RUN = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [TAG_W-1:0] tag_q;
  // MUL datapath
  logic [XLEN-1:0]  acc_q, mcand_q, mplier_q;
  logic [XLEN-1:0]  acc_next;
  // REM datapath
  logic [XLEN-1:0]  rem_q, dvd_q, dvs_q;
  logic             a_neg_q;
  logic [XLEN:0]    r_shift, r_diff;
  logic [XLEN-1:0]  rem_next, rem_final;

  logic is_mul, is_rem, rem_special, accept, last_iter;

  assign is_mul    = (alu_op == ALU_MUL);
  assign is_rem    = (alu_op == ALU_REM);
  // Divide-by-zero and the signed overflow case need no iterations.
  assign rem_special = (op_b == '0) || ((op_a == MOST_NEG) && (op_b == '1));
  assign last_iter = (cnt_q == CNT_LAST);

  // ---------------- next state / outputs ----------------
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (is_mul || is_rem) && !flush) begin
          accept = 1'b1;
          if (is_mul)           state_d = MUL_RUN;
          else if (rem_special) state_d = DONE;
          else                  state_d = REM_RUN;
        end
      end
      MUL_RUN, REM_RUN: begin
        if (flush)          state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // stall is low in DONE so that the pipeline advances on the same edge that
  // EX/MEM captures the result.
  assign stall        = accept || (state_q == MUL_RUN) || (state_q == REM_RUN);
  assign busy         = (state_q != IDLE);
  // A flush in DONE does not cancel a pulse that is already visible.
  assign result_valid = (state_q == DONE);
  assign state_dbg    = state_q;

  // ---------------- iteration arithmetic ----------------
  always_comb begin
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    // The partial remainder is always below the divisor (at most 2^(XLEN-1)),
    // so one extra bit is enough to hold the shifted value and its borrow.
    r_shift  = {rem_q, dvd_q[XLEN-1]};
    r_diff   = r_shift - {1'b0, dvs_q};
    rem_next = r_diff[XLEN] ? r_shift[XLEN-1:0] : r_diff[XLEN-1:0];
    rem_final = a_neg_q ? -rem_next : rem_next;
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      tag_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      a_neg_q    <= 1'b0;
      result     <= '0;
      result_tag <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      tag_q    <= rd_tag;
      acc_q    <= '0;
      mcand_q  <= op_a;
      mplier_q <= op_b;
      rem_q    <= '0;
      dvd_q    <= op_a[XLEN-1] ? -op_a : op_a;
      dvs_q    <= op_b[XLEN-1] ? -op_b : op_b;
      a_neg_q  <= op_a[XLEN-1];
      // Special-case REM results are known immediately.
      if (is_rem && rem_special) begin
        result     <= (op_b == '0) ? op_a : '0;
        result_tag <= rd_tag;
      end
    end else if ((state_q == MUL_RUN || state_q == REM_RUN) && flush) begin
      // An aborted operation leaves result and result_tag untouched.
      cnt_q <= '0;
    end else if (state_q == MUL_RUN) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (last_iter) begin
        cnt_q      <= '0;
        result     <= acc_next;
        result_tag <= tag_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (state_q == REM_RUN) begin
      rem_q <= rem_next;
      dvd_q <= dvd_q << 1;
      if (last_iter) begin
        cnt_q      <= '0;
        result     <= rem_final;
        result_tag <= tag_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Self-checking bench for muldiv_sequencer.
//   Directed cases and randomized MUL/REM operations are compared against a
//   behavioural model that uses plain integer arithmetic. The bench also
//   exercises flush, reset in the middle of an operation, and ignored ops.
module tb_muldiv_sequencer;

  localparam int         XLEN    = 32;
  localparam int         TAG_W   = 5;
  localparam logic [4:0] ALU_MUL = 5'd10;
  localparam logic [4:0] ALU_REM = 5'd13;
  localparam logic [4:0] ALU_ADD = 5'd0;

  logic             clk, reset, start, flush;
  logic [4:0]       alu_op;
  logic [XLEN-1:0]  op_a, op_b;
  logic [TAG_W-1:0] rd_tag;
  logic             stall, busy, result_valid;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] result_tag;
  logic [1:0]       state_dbg;

  muldiv_sequencer #(
    .XLEN(XLEN), .TAG_W(TAG_W), .ALU_MUL(ALU_MUL), .ALU_REM(ALU_REM)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op),
    .op_a(op_a), .op_b(op_b), .rd_tag(rd_tag), .flush(flush),
    .stall(stall), .busy(busy), .result_valid(result_valid),
    .result(result), .result_tag(result_tag), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0]  exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  logic [XLEN-1:0]  last_result;
  logic [TAG_W-1:0] last_tag;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the operation's definition.
  function automatic logic [XLEN-1:0] model(input logic is_mul, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [63:0] prod;
    if (is_mul) begin
      prod = {32'd0, a} * {32'd0, b};
      return prod[XLEN-1:0];
    end
    if (b == 0) return a;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
    return $signed(a) % $signed(b);
  endfunction

  // Issue one operation from a point #1 after a rising edge and follow it to
  // completion. On return the time is again #1 after a rising edge.
  task automatic run_op(input logic [4:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    bit   special;
    int   lat, stall_cnt;
    logic got_valid;
    logic [XLEN-1:0]  e_res;
    logic [TAG_W-1:0] e_tag;
    special = (op == ALU_REM) && ((b == 0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_q.push_back(model(op == ALU_MUL, a, b));
    exp_tag_q.push_back(tag);
    start = 1'b1; alu_op = op; op_a = a; op_b = b; rd_tag = tag;
    #2;
    check("stall_accept", stall, 1);
    @(posedge clk); #1;
    // Scramble the inputs so that the result depends only on latched values.
    start = 1'b0; op_a = $urandom; op_b = $urandom; rd_tag = TAG_W'($urandom);
    lat = 0; stall_cnt = 0; got_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (result_valid) begin
        got_valid = 1'b1;
        lat = c;
        break;
      end
      if (stall) stall_cnt++;
      @(posedge clk); #1;
    end
    check("valid_seen", got_valid, 1);
    e_res = exp_q.pop_front();
    e_tag = exp_tag_q.pop_front();
    if (got_valid) begin
      check("latency", lat, special ? 0 : XLEN);
      check("stall_cycles", stall_cnt, special ? 0 : XLEN);
      check("stall_done", stall, 0);
      check("busy_done", busy, 1);
      check("result", result, e_res);
      check("result_tag", result_tag, e_tag);
    end
    @(posedge clk); #1;
    check("valid_pulse_end", result_valid, 0);
    check("busy_after", busy, 0);
    check("result_hold", result, e_res);
    last_result = e_res;
    last_tag    = e_tag;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0]      op;
    logic [XLEN-1:0] a, b;

    reset = 1'b0; start = 1'b0; flush = 1'b0; alu_op = '0;
    op_a = '0; op_b = '0; rd_tag = '0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_tag", result_tag, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(ALU_MUL, 32'd7, 32'd6, 5'd3);
    run_op(ALU_MUL, 32'hFFFF_FFFD, 32'd5, 5'd1);
    run_op(ALU_MUL, 32'h8000_0000, 32'd2, 5'd2);
    run_op(ALU_REM, -32'sd7, 32'd2, 5'd4);
    run_op(ALU_REM, 32'd7, -32'sd2, 5'd5);
    run_op(ALU_REM, 32'd100, 32'd7, 5'd6);
    run_op(ALU_REM, 32'd13, 32'd0, 5'd7);
    run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);

    // Flush during iteration 10 of a MUL
    start = 1'b1; alu_op = ALU_MUL; op_a = 32'd12345; op_b = 32'd678; rd_tag = 5'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_valid", result_valid, 0);
    check("flush_result", result, last_result);
    check("flush_tag", result_tag, last_tag);
    run_op(ALU_MUL, 32'd3, 32'd3, 5'd9);

    // flush overrides start
    start = 1'b1; alu_op = ALU_MUL; op_a = 32'd5; op_b = 32'd5; rd_tag = 5'd10; flush = 1'b1;
    #2;
    check("flush_start_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 0);

    // flush in DONE: the visible pulse stands
    start = 1'b1; alu_op = ALU_REM; op_a = 32'd13; op_b = 32'd0; rd_tag = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_flush_valid", result_valid, 1);
    flush = 1'b1;
    #2;
    check("done_flush_valid_hold", result_valid, 1);
    check("done_flush_result", result, 32'd13);
    @(posedge clk); #1;
    flush = 1'b0;
    check("done_flush_busy", busy, 0);
    check("done_flush_nopulse", result_valid, 0);

    // Reset in the middle of a REM
    start = 1'b1; alu_op = ALU_REM; op_a = 32'd1000; op_b = 32'd7; rd_tag = 5'd12;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_result", result, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Non-MUL/REM op is ignored
    start = 1'b1; alu_op = ALU_ADD; op_a = 32'd1; op_b = 32'd2; rd_tag = 5'd3;
    #2;
    check("add_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("add_busy", busy, 0);
    check("add_valid", result_valid, 0);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 1) == 0) ? ALU_MUL : ALU_REM;
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = XLEN'($urandom_range(1, 15));
        3: b = -XLEN'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, TAG_W'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
